mem_8x4_ctrl: RTL and testbench

- Initiator/controller for the 8x4 asynchronous-read scratch memory.
- Accepts host commands over a valid/ready interface: single or burst fill-write, single or burst read.
- Converts each command into registered, glitch-free addr/data/wr_enable cycles on the memory port.
- Returns read data through a valid/ready response channel with backpressure.

---
 rtl/mem_8x4_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_8x4_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_8x4_ctrl.sv
// Command-driven controller for the 8x4 asynchronous-read scratch memory.
// Turns fill-write / burst-read commands into registered memory cycles and read responses.
module mem_8x4_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [ADDR_W-1:0] cmd_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_last,
   output logic              wr_done,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_wr_enable,
   input  logic [DATA_W-1:0] mem_data_out
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_SETUP, RD_RESP, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] beat;
   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] next_addr;

   assign next_addr = (addr_cnt == ADDR_W'(DEPTH - 1)) ? '0 : addr_cnt + ADDR_W'(1);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         beat          <= '0;
         addr_cnt      <= '0;
         len_q         <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_addr      <= '0;
         rsp_last      <= 1'b0;
         wr_done       <= 1'b0;
         mem_addr      <= '0;
         mem_data_in   <= '0;
         mem_wr_enable <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wr_done   <= 1'b0;
               rsp_valid <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  beat      <= '0;
                  addr_cnt  <= cmd_addr;
                  mem_addr  <= cmd_addr;
                  len_q     <= cmd_len;
                  if (cmd_write) begin
                     state         <= WRITE;
                     mem_wr_enable <= 1'b1;
                     mem_data_in   <= cmd_wdata;
                  end else begin
                     state         <= RD_SETUP;
                     mem_wr_enable <= 1'b0;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            WRITE: begin
               if (beat == len_q) begin
                  mem_wr_enable <= 1'b0;
                  wr_done       <= 1'b1;
                  state         <= DONE;
               end else begin
                  beat     <= beat + ADDR_W'(1);
                  addr_cnt <= next_addr;
                  mem_addr <= next_addr;
               end
            end
            DONE: begin
               wr_done   <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            RD_SETUP: begin
               // The memory read is combinational, so data for mem_addr is valid by this edge.
               rsp_data  <= mem_data_out;
               rsp_addr  <= mem_addr;
               rsp_last  <= (beat == len_q);
               rsp_valid <= 1'b1;
               state     <= RD_RESP;
            end
            RD_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (rsp_last) begin
                     cmd_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     beat     <= beat + ADDR_W'(1);
                     addr_cnt <= next_addr;
                     mem_addr <= next_addr;
                     state    <= RD_SETUP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_8x4_ctrl.sv
// Bench for mem_8x4_ctrl: directed table, hand-written corner sequences and random commands
// checked against a command-level model of the memory contents.
module tb_mem_8x4_ctrl;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 4;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_write = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic [ADDR_W-1:0] cmd_len = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] rsp_addr;
   logic              rsp_last;
   logic              wr_done;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_wr_enable;
   logic [DATA_W-1:0] mem_data_out;

   mem_8x4_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_last(rsp_last), .wr_done(wr_done), .busy(busy),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr_enable(mem_wr_enable),
      .mem_data_out(mem_data_out)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // The scratch memory itself: asynchronous read, synchronous write
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
   assign mem_data_out = mem[mem_addr];
   always @(posedge clk) if (mem_wr_enable) mem[mem_addr] <= mem_data_in;

   // Reference model: expected memory contents, updated per command
   logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept_wait", cmd_ready, 1);
   endtask

   // Driver: fill-write; optionally keep cmd_valid high with the next command's fields
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [ADDR_W-1:0] len, input bit hold,
                           input logic [ADDR_W-1:0] na, input logic [DATA_W-1:0] nd,
                           input logic [ADDR_W-1:0] nlen);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_len = len;
      wait_ready();
      @(negedge clk);
      if (hold) begin
         cmd_addr = na; cmd_wdata = nd; cmd_len = nlen;
      end else begin
         cmd_valid = 1'b0;
      end
      for (int b = 0; b <= int'(len); b++) begin
         check("wr_enable", mem_wr_enable, 1);
         check("wr_addr", mem_addr, (int'(a) + b) % DEPTH);
         check("wr_data", mem_data_in, d);
         check("wr_cmd_ready", cmd_ready, 0);
         check("wr_done_early", wr_done, 0);
         ref_mem[(int'(a) + b) % DEPTH] = d;
         @(negedge clk);
      end
      check("wr_done", wr_done, 1);
      check("wr_enable_done", mem_wr_enable, 0);
      check("wr_ready_done", cmd_ready, 0);
      @(negedge clk);
      check("wr_ready_back", cmd_ready, 1);
      check("wr_done_once", wr_done, 0);
      check("wr_idle_busy", busy, 0);
      check("wr_enable_idle", mem_wr_enable, 0);
   endtask

   // Driver + scoreboard: burst read with an optional stall on one beat
   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len,
                          input int stall_beat, input int stall_cyc,
                          output logic [DATA_W-1:0] first);
      logic [DATA_W-1:0] exp;
      int n;
      first = '0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
      cmd_wdata = DATA_W'($urandom_range(15));
      rsp_ready = 1'b1;
      for (int b = 0; b <= int'(len); b++) exp_q.push_back(ref_mem[(int'(a) + b) % DEPTH]);
      wait_ready();
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rd_setup_valid", rsp_valid, 0);
      check("rd_setup_addr", mem_addr, a);
      check("rd_setup_wren", mem_wr_enable, 0);
      check("rd_busy", busy, 1);
      for (int b = 0; b <= int'(len); b++) begin
         n = 0;
         while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("rd_latency", n, 1);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         if (b == 0) first = rsp_data;
         check("rd_data", rsp_data, exp);
         check("rd_addr", rsp_addr, (int'(a) + b) % DEPTH);
         check("rd_last", rsp_last, (b == int'(len)) ? 1 : 0);
         check("rd_wren", mem_wr_enable, 0);
         if (b == stall_beat) begin
            rsp_ready = 1'b0;
            repeat (stall_cyc) begin
               @(negedge clk);
               check("stall_valid", rsp_valid, 1);
               check("stall_data", rsp_data, exp);
               check("stall_addr", rsp_addr, (int'(a) + b) % DEPTH);
            end
            rsp_ready = 1'b1;
         end
         @(negedge clk);
      end
      check("rd_end_valid", rsp_valid, 0);
      check("rd_end_ready", cmd_ready, 1);
      check("rd_end_busy", busy, 0);
      check("rd_queue_empty", exp_q.size(), 0);
   endtask

   typedef struct {
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] len;
      int                stall_beat;
      int                stall_cyc;
      logic [DATA_W-1:0] exp_first;
   } vec_t;

   vec_t              vecs [7];
   logic [DATA_W-1:0] first;
   bit                r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_len;
   logic [DATA_W-1:0] r_data;
   int                r_sb;

   initial begin
      vecs[0] = '{1'b1, 3'd3, 4'hA, 3'd0, -1, 0, 4'h0};
      vecs[1] = '{1'b0, 3'd3, 4'h0, 3'd0, -1, 0, 4'hA};
      vecs[2] = '{1'b1, 3'd6, 4'h5, 3'd3, -1, 0, 4'h0};
      vecs[3] = '{1'b0, 3'd0, 4'h0, 3'd7, -1, 0, 4'h5};
      vecs[4] = '{1'b0, 3'd2, 4'h0, 3'd2,  1, 3, 4'h0};
      vecs[5] = '{1'b0, 3'd7, 4'h0, 3'd1,  0, 2, 4'h5};
      vecs[6] = '{1'b0, 3'd5, 4'h0, 3'd7, -1, 0, 4'h0};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_wren", mem_wr_enable, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_wr_done", wr_done, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_data", rsp_data, 0);
      rst_n = 1'b1;
      #1 check("rel_cmd_ready_low", cmd_ready, 0);
      @(negedge clk);
      check("rel_cmd_ready_high", cmd_ready, 1);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].len, 1'b0, '0, '0, '0);
         end else begin
            do_read(vecs[i].addr, vecs[i].len, vecs[i].stall_beat, vecs[i].stall_cyc, first);
            check("table_first", first, vecs[i].exp_first);
         end
      end

      // cmd_valid held across a write: the next command waits for DONE
      do_write(3'd4, 4'hC, 3'd2, 1'b1, 3'd5, 4'h3, 3'd1);
      do_write(3'd5, 4'h3, 3'd1, 1'b0, '0, '0, '0);
      do_read(3'd4, 3'd3, -1, 0, first);
      check("hold_first", first, 4'hC);

      // Reset during the third beat of an 8-beat write
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd0; cmd_wdata = 4'h9; cmd_len = 3'd7;
      wait_ready();
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_pre_wren", mem_wr_enable, 1);
      check("abort_pre_addr", mem_addr, 2);
      rst_n = 1'b0;
      #1;
      check("abort_wren", mem_wr_enable, 0);
      check("abort_ready", cmd_ready, 0);
      ref_mem[0] = 4'h9;
      ref_mem[1] = 4'h9;
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", wr_done, 0);
         check("abort_no_rsp", rsp_valid, 0);
      end
      for (int i = 0; i < DEPTH; i++) check("abort_mem", mem[i], ref_mem[i]);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready_back", cmd_ready, 1);
      check("abort_busy", busy, 0);
      do_read(3'd0, 3'd2, -1, 0, first);
      check("abort_first", first, 4'h9);

      // Random commands against the model
      for (int i = 0; i < 30; i++) begin
         r_wr   = 1'($urandom_range(1));
         r_addr = ADDR_W'($urandom_range(DEPTH - 1));
         r_len  = ADDR_W'($urandom_range(DEPTH - 1));
         r_data = DATA_W'($urandom_range(15));
         if (r_wr) begin
            do_write(r_addr, r_data, r_len, 1'b0, '0, '0, '0);
         end else begin
            r_sb = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(int'(r_len)));
            do_read(r_addr, r_len, r_sb, int'($urandom_range(1, 3)), first);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
